// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank with independent AW/W capture,
// per-register read-only sourcing from reg_in, and access strobes.
module axil_reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    REG_NUM    = 16,
    parameter logic [REG_NUM-1:0]    RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [ADDR_WIDTH-1:0]         s_awaddr,
    input  logic [2:0]                    s_awprot,

    input  logic                          s_wvalid,
    output logic                          s_wready,
    input  logic [DATA_WIDTH-1:0]         s_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_wstrb,

    output logic                          s_bvalid,
    input  logic                          s_bready,
    output logic [1:0]                    s_bresp,

    input  logic                          s_arvalid,
    output logic                          s_arready,
    input  logic [ADDR_WIDTH-1:0]         s_araddr,

    output logic                          s_rvalid,
    input  logic                          s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,

    output logic [REG_NUM*DATA_WIDTH-1:0] reg_out,
    input  logic [REG_NUM*DATA_WIDTH-1:0] reg_in,
    output logic [REG_NUM-1:0]            wr_pulse,
    output logic [REG_NUM-1:0]            rd_pulse
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  aw_held;
    logic                  w_held;
    logic [IW-1:0]         aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic                  commit;
    logic                  aw_ok;
    logic                  ar_hs;
    logic                  ar_hit;
    logic [IW-1:0]         ar_idx;
    logic [DATA_WIDTH-1:0] ar_data;

    logic unused_bits;
    assign unused_bits = ^{s_awprot, s_awaddr[OFS-1:0], s_araddr[OFS-1:0]};

    assign ar_idx = s_araddr[ADDR_WIDTH-1:OFS];
    assign ar_hs  = s_arvalid && s_arready;

    // Write FSM: readies and the commit strobe are gated by reset so
    // nothing is accepted or committed while aresetn is low.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next    = w_state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        commit    = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_awready = aresetn && !aw_held;
                s_wready  = aresetn && !w_held;
                commit    = aresetn && aw_held && w_held;
                if (commit) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_next = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_awaddr[ADDR_WIDTH-1:OFS];
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        wr_pulse = '0;
        aw_ok    = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (aw_idx == IW'(i) && !RO_MASK[i]) begin
                aw_ok       = 1'b1;
                wr_pulse[i] = commit;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_pulse[i]) begin
                    for (int j = 0; j < NB; j++) begin
                        if (w_strb[j]) begin
                            regs[i][8*j +: 8] <= w_data[8*j +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read FSM: data is sampled at the AR handshake edge, so a read
    // coinciding with a commit sees the pre-write value.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next    = r_state;
        s_arready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_arready = aresetn;
                if (s_arvalid && aresetn) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_next = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ar_hit   = 1'b0;
        ar_data  = '0;
        rd_pulse = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (ar_idx == IW'(i)) begin
                ar_hit      = 1'b1;
                ar_data     = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH]
                                         : regs[i];
                rd_pulse[i] = ar_hs;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= ar_data;
            s_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
                RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: 16 x 32-bit registers,
// register 3 read-only and fed from reg_in.
module tb_axil_reg_bank;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         awvalid, awready;
    logic [11:0]  awaddr;
    logic [2:0]   awprot;
    logic         wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [11:0]  araddr;
    logic         rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic [511:0] reg_out;
    logic [511:0] reg_in;
    logic [15:0]  wr_pulse, rd_pulse;

    int total = 0;
    int bad   = 0;

    logic [15:0] pl;
    logic [1:0]  rs;
    logic [31:0] dv;

    always #5 aclk = ~aclk;

    axil_reg_bank #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .REG_NUM(16),
        .RO_MASK(16'h0008),
        .RESET_VAL(32'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(awvalid), .s_awready(awready),
        .s_awaddr(awaddr), .s_awprot(awprot),
        .s_wvalid(wvalid), .s_wready(wready),
        .s_wdata(wdata), .s_wstrb(wstrb),
        .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp),
        .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr),
        .s_rvalid(rvalid), .s_rready(rready),
        .s_rdata(rdata), .s_rresp(rresp),
        .reg_out(reg_out), .reg_in(reg_in),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] r(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic axw(input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] st, output logic [15:0] pulse,
                       output logic [1:0] resp);
        logic awd, wd, fa, fw;
        int n;
        awvalid = 1'b1; awaddr = a;
        wvalid = 1'b1; wdata = d; wstrb = st;
        bready = 1'b1;
        awd = 1'b0; wd = 1'b0; n = 0;
        #1;
        while (!(awd && wd) && n < 20) begin
            fa = awvalid && awready;
            fw = wvalid && wready;
            tick();
            if (fa) begin awd = 1'b1; awvalid = 1'b0; end
            if (fw) begin wd = 1'b1; wvalid = 1'b0; end
            n++;
        end
        chk("aw_w_accept", {63'd0, awd && wd}, 64'd1);
        pulse = wr_pulse;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("bvalid_rise", {63'd0, bvalid}, 64'd1);
        resp = bresp;
        tick();
    endtask

    task automatic axr(input logic [11:0] a, output logic [31:0] d,
                       output logic [1:0] resp, output logic [15:0] pulse);
        int n;
        arvalid = 1'b1; araddr = a; rready = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        pulse = rd_pulse;
        tick();
        arvalid = 1'b0;
        chk("rvalid_latency", {63'd0, rvalid}, 64'd1);
        d = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b010;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        reg_in = '0;
        reg_in[3*32 +: 32] = 32'hDEAD_BEEF;

        tick();
        tick();
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_pulses", {32'd0, wr_pulse, rd_pulse}, 64'd0);
        chk("rst_reg0", {32'd0, r(0)}, 64'd0);
        chk("rst_reg2", {32'd0, r(2)}, 64'd0);

        aresetn = 1'b1;
        tick();
        chk("rel_awready", {63'd0, awready}, 64'd1);
        chk("rel_wready", {63'd0, wready}, 64'd1);
        chk("rel_arready", {63'd0, arready}, 64'd1);

        // basic full-word write and readback of register 2
        axw(12'h008, 32'hA5A5_1234, 4'hF, pl, rs);
        chk("w2_pulse", {48'd0, pl}, 64'h0004);
        chk("w2_bresp", {62'd0, rs}, 64'd0);
        chk("w2_reg", {32'd0, r(2)}, 64'hA5A5_1234);
        axr(12'h008, dv, rs, pl);
        chk("r2_data", {32'd0, dv}, 64'hA5A5_1234);
        chk("r2_rresp", {62'd0, rs}, 64'd0);
        chk("r2_pulse", {48'd0, pl}, 64'h0004);
        axr(12'h00B, dv, rs, pl);
        chk("r2_lowbits_data", {32'd0, dv}, 64'hA5A5_1234);

        // W first, AW five cycles later, partial strobes
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b0101;
        bready = 1'b1;
        #1;
        chk("wfirst_wready", {63'd0, wready}, 64'd1);
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("wfirst_wait_wready", {63'd0, wready}, 64'd0);
            chk("wfirst_wait_bvalid", {63'd0, bvalid}, 64'd0);
            tick();
        end
        awvalid = 1'b1; awaddr = 12'h004;
        #1;
        chk("wfirst_awready", {63'd0, awready}, 64'd1);
        tick();
        awvalid = 1'b0;
        chk("wfirst_pulse", {48'd0, wr_pulse}, 64'h0002);
        tick();
        chk("wfirst_bvalid", {63'd0, bvalid}, 64'd1);
        chk("wfirst_bresp", {62'd0, bresp}, 64'd0);
        chk("wfirst_reg1", {32'd0, r(1)}, 64'h00FF_00FF);
        tick();
        chk("wfirst_bdone", {63'd0, bvalid}, 64'd0);

        // read-only register 3
        axr(12'h00C, dv, rs, pl);
        chk("ro_data", {32'd0, dv}, 64'hDEAD_BEEF);
        chk("ro_rresp", {62'd0, rs}, 64'd0);
        chk("ro_rpulse", {48'd0, pl}, 64'h0008);
        axw(12'h00C, 32'h1234_5678, 4'hF, pl, rs);
        chk("ro_bresp", {62'd0, rs}, 64'd2);
        chk("ro_wpulse", {48'd0, pl}, 64'd0);

        // out-of-range index 16
        axw(12'h040, 32'hFFFF_FFFF, 4'hF, pl, rs);
        chk("oor_bresp", {62'd0, rs}, 64'd2);
        chk("oor_wpulse", {48'd0, pl}, 64'd0);
        chk("oor_reg1", {32'd0, r(1)}, 64'h00FF_00FF);
        chk("oor_reg2", {32'd0, r(2)}, 64'hA5A5_1234);
        axr(12'h040, dv, rs, pl);
        chk("oor_rdata", {32'd0, dv}, 64'd0);
        chk("oor_rresp", {62'd0, rs}, 64'd2);
        chk("oor_rpulse", {48'd0, pl}, 64'd0);

        // last register, top byte only
        axw(12'h03C, 32'hCAFE_0001, 4'b1000, pl, rs);
        chk("last_pulse", {48'd0, pl}, 64'h8000);
        chk("last_bresp", {62'd0, rs}, 64'd0);
        axr(12'h03C, dv, rs, pl);
        chk("last_rdata", {32'd0, dv}, 64'hCA00_0000);

        // concurrent write/read, then responses stalled 10 cycles
        awvalid = 1'b1; awaddr = 12'h014;
        wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h008;
        bready = 1'b0; rready = 1'b0;
        #1;
        chk("stall_aw_rdy", {63'd0, awready}, 64'd1);
        chk("stall_ar_rdy", {63'd0, arready}, 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("stall_commit", {48'd0, wr_pulse}, 64'h0020);
        chk("stall_rvalid", {63'd0, rvalid}, 64'd1);
        tick();
        chk("stall_bvalid", {63'd0, bvalid}, 64'd1);
        awvalid = 1'b1; awaddr = 12'h018;
        wvalid = 1'b1; wdata = 32'h9999_9999;
        arvalid = 1'b1; araddr = 12'h004;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_awready", {63'd0, awready}, 64'd0);
            chk("stall_wready", {63'd0, wready}, 64'd0);
            chk("stall_arready", {63'd0, arready}, 64'd0);
            chk("stall_bvalid_hold", {63'd0, bvalid}, 64'd1);
            chk("stall_bresp_hold", {62'd0, bresp}, 64'd0);
            chk("stall_rvalid_hold", {63'd0, rvalid}, 64'd1);
            chk("stall_rdata_hold", {32'd0, rdata}, 64'hA5A5_1234);
            chk("stall_rresp_hold", {62'd0, rresp}, 64'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick();
        chk("stall_bdone", {63'd0, bvalid}, 64'd0);
        chk("stall_rdone", {63'd0, rvalid}, 64'd0);
        chk("stall_reg5", {32'd0, r(5)}, 64'h1122_3344);
        chk("stall_reg6", {32'd0, r(6)}, 64'd0);

        // read captured in the commit cycle sees the old value
        awvalid = 1'b1; awaddr = 12'h008;
        wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 12'h008; rready = 1'b1;
        #1;
        chk("rw_commit_pulse", {48'd0, wr_pulse}, 64'h0004);
        chk("rw_arready", {63'd0, arready}, 64'd1);
        tick();
        arvalid = 1'b0;
        chk("rw_rvalid", {63'd0, rvalid}, 64'd1);
        chk("rw_old_data", {32'd0, rdata}, 64'hA5A5_1234);
        chk("rw_bvalid", {63'd0, bvalid}, 64'd1);
        chk("rw_new_reg", {32'd0, r(2)}, 64'h0BAD_F00D);
        tick();

        // reset pulse between AW and W abandons the write
        awvalid = 1'b1; awaddr = 12'h010;
        tick();
        awvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        chk("mid_rst_awready", {63'd0, awready}, 64'd0);
        chk("mid_rst_wready", {63'd0, wready}, 64'd0);
        chk("mid_rst_arready", {63'd0, arready}, 64'd0);
        chk("mid_rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
        chk("mid_rst_pulses", {32'd0, wr_pulse, rd_pulse}, 64'd0);
        chk("mid_rst_reg2", {32'd0, r(2)}, 64'd0);
        aresetn = 1'b1;
        tick();
        chk("mid_rel_awready", {63'd0, awready}, 64'd1);
        chk("mid_rel_wready", {63'd0, wready}, 64'd1);
        chk("mid_rel_arready", {63'd0, arready}, 64'd1);
        wvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_bvalid", {63'd0, bvalid}, 64'd0);
            chk("mid_no_wpulse", {48'd0, wr_pulse}, 64'd0);
            tick();
        end
        chk("mid_reg4", {32'd0, r(4)}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte address width.
REQ-003 SHALL have parameter REG_NUM, default 16, number of registers (1..2^(ADDR_WIDTH-OFS), OFS=log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter RO_MASK, default 0, REG_NUM-bit mask; bit i=1 makes register i read-only, sourced from reg_in.
REQ-005 SHALL have parameter RESET_VAL, default 0, DATA_WIDTH-bit reset value of every RW register.
REQ-006 SHALL have ports aclk in 1 clock; aresetn in 1 synchronous active-low reset.
REQ-007 SHALL have AW ports: s_awvalid in 1; s_awready out 1; s_awaddr in ADDR_WIDTH; s_awprot in 3, ignored.
REQ-008 SHALL have W ports: s_wvalid in 1; s_wready out 1; s_wdata in DATA_WIDTH; s_wstrb in DATA_WIDTH/8.
REQ-009 SHALL have B ports: s_bvalid out 1; s_bready in 1; s_bresp out 2.
REQ-010 SHALL have AR ports: s_arvalid in 1; s_arready out 1; s_araddr in ADDR_WIDTH.
REQ-011 SHALL have R ports: s_rvalid out 1; s_rready in 1; s_rdata out DATA_WIDTH; s_rresp out 2.
REQ-012 SHALL have user ports: reg_out out REG_NUM*DATA_WIDTH, register i at [i*DATA_WIDTH +: DATA_WIDTH]; reg_in in REG_NUM*DATA_WIDTH, same packing; wr_pulse out REG_NUM; rd_pulse out REG_NUM.

Function
REQ-013 Register index SHALL be addr[ADDR_WIDTH-1:OFS]; low OFS bits ignored; index >= REG_NUM is out-of-range.
REQ-014 Write FSM SHALL have states W_IDLE, W_RESP; AW and W accepted independently in W_IDLE, each latched into a hold register with a held flag.
REQ-015 In W_IDLE, s_awready SHALL be !aw_held and s_wready SHALL be !w_held; both 0 in W_RESP.
REQ-016 Cycle after both held flags are 1: write commits, s_bvalid rises, FSM enters W_RESP, held flags clear.
REQ-017 Commit SHALL update byte j of an in-range RW register only where wstrb[j]=1; update visible on reg_out in the cycle s_bvalid first reads 1.
REQ-018 wr_pulse[i] SHALL be 1 for exactly the commit cycle when register i (RW, in-range) is written, regardless of strobes.
REQ-019 s_bresp SHALL be 2'b00 for in-range RW, 2'b10 (SLVERR) for out-of-range or RO targets; SLVERR writes change no state and pulse nothing.
REQ-020 s_bvalid and s_bresp SHALL hold until s_bready=1; on that handshake FSM returns to W_IDLE, readies reassert next cycle.
REQ-021 Read FSM SHALL have states R_IDLE, R_DATA; s_arready=1 only in R_IDLE.
REQ-022 On AR handshake, s_rdata/s_rresp SHALL be registered and s_rvalid rise next cycle (1-cycle latency); FSM enters R_DATA.
REQ-023 Read data SHALL be reg_in[i] for RO, register value for RW, 0 with s_rresp=2'b10 for out-of-range; otherwise s_rresp=2'b00.
REQ-024 rd_pulse[i] SHALL be 1 for one cycle coincident with the AR handshake of an in-range index i.
REQ-025 s_rvalid, s_rdata, s_rresp SHALL be stable until s_rready=1; then FSM returns to R_IDLE.
REQ-026 Read and write FSMs SHALL run concurrently; a read captured in the commit cycle of the same register SHALL return the pre-write value.
REQ-027 W accepted before AW (or vice versa) SHALL be held indefinitely without loss until the partner arrives.

Reset
REQ-028 With aresetn=0 at a clock edge: RW registers=RESET_VAL; s_awready=s_wready=s_arready=0; s_bvalid=s_rvalid=0; s_bresp=s_rresp=0; s_rdata=0; wr_pulse=rd_pulse=0; held flags clear; FSMs to W_IDLE/R_IDLE.
REQ-029 First cycle after aresetn=1, s_awready, s_wready, s_arready SHALL be 1.
REQ-030 Reset asserted mid-transaction SHALL abandon it: no commit, no response issued after release.

Verification
REQ-031 Write addr 0x008 data 0xA5A5_1234 strb 4'hF, bready=1 -> reg 2 = 0xA5A5_1234, wr_pulse[2] one cycle, bresp 00; read 0x008 -> rdata 0xA5A5_1234, rresp 00.
REQ-032 W beat 0xFFFF_FFFF strb 4'b0101 to reg 1 (reset 0), AW 5 cycles later -> reg 1 = 0x00FF_00FF; wready=0 during wait.
REQ-033 RO_MASK bit 3 set, reg_in[3]=0xDEAD_BEEF: read 0x00C -> 0xDEAD_BEEF, rd_pulse[3]; write 0x00C -> bresp 10, no wr_pulse.
REQ-034 REG_NUM=16: write/read 0x040 -> bresp 10 / rresp 10, rdata 0, no state change.
REQ-035 bready and rready held 0 for 10 cycles -> bvalid/rvalid, resp, rdata stable; no new AW/W/AR accepted.
REQ-036 aresetn pulsed low for one cycle between AW and W handshakes -> no commit, all outputs per REQ-028, readies 1 next cycle.
